z80_im2_int_ctrl: RTL and testbench

//   Prioritising IM2 interrupt controller for the A-Z80 host board. Latches

---
 rtl/z80_im2_int_ctrl.sv | 154 +++++++++++++++
 tb/tb_z80_im2_int_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_im2_int_ctrl.sv
// z80_im2_int_ctrl: prioritising Z80 IM2 interrupt controller with mask, status and EOI IO ports.
// Optional macro Z80_INT_NESTED_EN lets a higher-priority source preempt one already in service.
module z80_im2_int_ctrl #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] VEC_BASE  = 8'h80,
  parameter logic [7:0] MASK_PORT = 8'h04,
  parameter logic [7:0] STAT_PORT = 8'h05,
  parameter logic [7:0] EOI_PORT  = 8'h06
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               nM1,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  input  logic [7:0]         Address,
  input  logic [7:0]         DataIn,
  output logic [7:0]         DataOut,
  output logic               DataOe,
  output logic               nINT
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_VECTOR} state_t;
  localparam logic [7:0] VEC_SPUR = VEC_BASE + 8'(2 * NUM_SRC);

  state_t             state;
  logic [NUM_SRC-1:0] pending, in_service, mask;
  logic [NUM_SRC-1:0] prio_ok, eligible, win_oh, eoi_oh, pend_clr, isv_clr;
  logic [NUM_SRC-1:0] irq_s1, irq_s2, irq_s3, irq_rise;
  logic [3:0]         pin_s1, pin_s2;
  logic [2:0]         win_idx;
  logic [7:0]         stat_val, mask_val, rd_data;
  logic               m1, iorq, rd, wr, inta, io_rd, io_wr, inta_q, wr_q;
  logic               inta_go, wr_go, take_vec, rd_hit;
  logic               data_unused;

  // Synchronisers and edge history carry no reset, so a strobe or request
  // held across reset is not mistaken for a fresh edge once reset drops.
  always_ff @(posedge clk) begin
    pin_s1 <= {nM1, nIORQ, nRD, nWR};
    pin_s2 <= pin_s1;
    irq_s1 <= irq_req;
    irq_s2 <= irq_s1;
    irq_s3 <= irq_s2;
    inta_q <= inta;
    wr_q   <= io_wr;
  end

  assign {m1, iorq, rd, wr} = pin_s2;
  assign inta     = ~m1 & ~iorq;
  assign io_rd    = ~iorq & ~rd & m1;
  assign io_wr    = ~iorq & ~wr & m1;
  assign inta_go  = inta & ~inta_q;
  assign wr_go    = io_wr & ~wr_q;
  assign irq_rise = irq_s2 & ~irq_s3;
  assign data_unused = ^DataIn;

`ifdef Z80_INT_NESTED_EN
  logic nest_blk;
  // Only sources strictly above the highest-priority in-service level may interrupt.
  always_comb begin
    nest_blk = 1'b0;
    prio_ok  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nest_blk   = nest_blk | in_service[i];
      prio_ok[i] = ~nest_blk;
    end
  end
`else
  assign prio_ok = (in_service == '0) ? '1 : '0;
`endif

  assign eligible = pending & ~mask & prio_ok;

  // Descending scan leaves the lowest set index as the winner.
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    eoi_oh  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx   = 3'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
      if (in_service[i]) begin
        eoi_oh    = '0;
        eoi_oh[i] = 1'b1;
      end
    end
  end

  assign take_vec = (state != S_VECTOR) & inta_go & (|eligible);
  assign pend_clr = take_vec ? win_oh : '0;
  assign isv_clr  = (wr_go && Address == EOI_PORT) ? eoi_oh : '0;

  always_comb begin
    stat_val = '0;
    mask_val = '0;
    mask_val[NUM_SRC-1:0] = mask;
    for (int i = 0; i < NUM_SRC && i < 4; i++) begin
      stat_val[i]     = pending[i];
      stat_val[4 + i] = in_service[i];
    end
    rd_data = (Address == MASK_PORT) ? mask_val : stat_val;
  end

  assign rd_hit = io_rd & ((Address == MASK_PORT) | (Address == STAT_PORT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      nINT       <= 1'b1;
      DataOe     <= 1'b0;
      DataOut    <= 8'h00;
      pending    <= '0;
      in_service <= '0;
      mask       <= '1;
    end else begin
      // A new edge in the same cycle as the acknowledge clear keeps the bit set.
      pending    <= (pending & ~pend_clr) | irq_rise;
      in_service <= (in_service & ~isv_clr) | pend_clr;
      if (wr_go && Address == MASK_PORT) mask <= DataIn[NUM_SRC-1:0];

      case (state)
        S_IDLE, S_ASSERT: begin
          if (inta_go) begin
            state   <= S_VECTOR;
            nINT    <= 1'b1;
            DataOe  <= 1'b1;
            DataOut <= (|eligible) ? VEC_BASE + {4'b0, win_idx, 1'b0} : VEC_SPUR;
          end else begin
            DataOe <= rd_hit;
            if (rd_hit) DataOut <= rd_data;
            if (|eligible) begin
              state <= S_ASSERT;
              nINT  <= 1'b0;
            end else begin
              state <= S_IDLE;
              nINT  <= 1'b1;
            end
          end
        end
        S_VECTOR: begin
          if (iorq) begin
            DataOe <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z80_im2_int_ctrl.sv
// tb_z80_im2_int_ctrl: directed bench with a transaction-level model of the interrupt
// controller, a per-cycle output comparator, and hand-computed literal checks.
module tb_z80_im2_int_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_req = '0;
  logic         nM1 = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1;
  logic [7:0]   Address = 8'h00, DataIn = 8'h00;
  logic [7:0]   DataOut;
  logic         DataOe, nINT;

  z80_im2_int_ctrl dut (
    .clk(clk), .reset(reset), .irq_req(irq_req),
    .nM1(nM1), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .Address(Address), .DataIn(DataIn),
    .DataOut(DataOut), .DataOe(DataOe), .nINT(nINT)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, chg_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: sets of pending / in-service sources, mask, and what the bus is doing.
  bit [N-1:0] m_pend = '0, m_isv = '0, m_mask = '1;
  int         m_phase = 0;          // 0 none, 1 INTA, 2 IO read
  logic [7:0] m_vec = 8'h00, m_port = 8'h00;

  function automatic bit [N-1:0] allowed();
    bit [N-1:0] a;
`ifdef Z80_INT_NESTED_EN
    a = '0;
    for (int i = 0; i < N; i++) begin
      if (m_isv[i]) break;
      a[i] = 1'b1;
    end
`else
    a = (m_isv == '0) ? '1 : '0;
`endif
    return a;
  endfunction

  function automatic bit [N-1:0] elig();
    return m_pend & ~m_mask & allowed();
  endfunction

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] rd_val(input logic [7:0] p);
    if (p == 8'h04) return {4'h0, m_mask};
    return {m_isv, m_pend};
  endfunction

  function automatic int exp_nint();
    if (m_phase == 1) return 1;
    return (elig() != '0) ? 0 : 1;
  endfunction

  function automatic int exp_oe();
    if (m_phase == 1) return 1;
    if (m_phase == 2 && (m_port == 8'h04 || m_port == 8'h05)) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outputs are compared once the pins have been quiet long enough to propagate.
  always @(negedge clk) begin
    if (!reset && (cyc - chg_cyc) >= 6) begin
      chk("cmp_nINT", int'(nINT), exp_nint());
      chk("cmp_DataOe", int'(DataOe), exp_oe());
      if (exp_oe() == 1)
        chk("cmp_DataOut", int'(DataOut), int'(m_phase == 1 ? m_vec : rd_val(m_port)));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic mark();
    chg_cyc = cyc;
  endtask

  task automatic irq_pulse(input logic [N-1:0] bits);
    tick(1);
    irq_req = irq_req | bits;
    m_pend  = m_pend | bits;
    mark();
    tick(3);
    irq_req = irq_req & ~bits;
    mark();
    tick(6);
  endtask

  task automatic io_write(input logic [7:0] port, input logic [7:0] d);
    int w;
    tick(1);
    Address = port; DataIn = d; nIORQ = 1'b0; nWR = 1'b0;
    mark();
    if (port == 8'h04) m_mask = d[N-1:0];
    else if (port == 8'h06) begin
      w = lowest(m_isv);
      if (w >= 0) m_isv[w] = 1'b0;
    end
    tick(6);
    nIORQ = 1'b1; nWR = 1'b1;
    mark();
    tick(6);
  endtask

  task automatic io_read(input logic [7:0] port, output logic [7:0] val, output logic oe);
    tick(1);
    Address = port; nIORQ = 1'b0; nRD = 1'b0;
    mark();
    m_phase = 2; m_port = port;
    tick(7);
    val = DataOut; oe = DataOe;
    nIORQ = 1'b1; nRD = 1'b1;
    mark();
    m_phase = 0;
    tick(6);
  endtask

  // Begins an acknowledge; optionally raises request lines on the same instant.
  task automatic inta_begin(input logic [N-1:0] set_bits);
    int w;
    tick(1);
    nM1 = 1'b0; nIORQ = 1'b0;
    irq_req = irq_req | set_bits;
    mark();
    w = lowest(elig());
    if (w >= 0) begin
      m_vec = 8'h80 + 8'(2 * w);
      m_pend[w] = 1'b0;
      m_isv[w]  = 1'b1;
    end else m_vec = 8'h80 + 8'(2 * N);
    m_pend  = m_pend | set_bits;
    m_phase = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("inta_lat_2clk_oe", int'(DataOe), 0);
    @(posedge clk); #1;
    chk("inta_lat_3clk_oe", int'(DataOe), 1);
  endtask

  task automatic inta(input logic [N-1:0] set_bits, output logic [7:0] vec);
    inta_begin(set_bits);
    tick(4);
    vec = DataOut;
    nM1 = 1'b1; nIORQ = 1'b1;
    irq_req = irq_req & ~set_bits;
    mark();
    m_phase = 0;
    tick(6);
  endtask

  logic [7:0] v;
  logic       oe;
  int         lat;

  initial begin
    mark();
    tick(8);
    chk("rst_nINT", int'(nINT), 1);
    chk("rst_DataOe", int'(DataOe), 0);
    chk("rst_DataOut", int'(DataOut), 8'h00);
    reset = 1'b0;
    mark();
    tick(6);
    io_read(8'h04, v, oe); chk("rst_mask_rd", int'(v), 8'h0F); chk("rst_mask_oe", int'(oe), 1);
    io_read(8'h05, v, oe); chk("rst_stat_rd", int'(v), 8'h00);

    // 1: single source, vector, status, EOI gating
    io_write(8'h04, 8'h00);
    tick(1);
    irq_req[2] = 1'b1; m_pend[2] = 1'b1;
    mark();
    lat = 0;
    while (nINT && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("t1_irq_to_nint_le4", int'(lat >= 1 && lat <= 4), 1);
    irq_req[2] = 1'b0;
    mark();
    tick(6);
    inta('0, v); chk("t1_vec", int'(v), 8'h84);
    io_read(8'h05, v, oe); chk("t1_stat", int'(v), 8'h40);
    tick(10); chk("t1_nint_held", int'(nINT), 1);
    io_write(8'h06, 8'h00);
    io_read(8'h05, v, oe); chk("t1_stat_eoi", int'(v), 8'h00);

    // 2: two simultaneous sources served in priority order
    irq_pulse(4'b1010);
    chk("t2_nint", int'(nINT), 0);
    inta('0, v); chk("t2_vec_a", int'(v), 8'h82);
    io_read(8'h05, v, oe); chk("t2_stat", int'(v), 8'h28);
    io_write(8'h06, 8'h00);
    chk("t2_nint_reassert", int'(nINT), 0);
    inta('0, v); chk("t2_vec_b", int'(v), 8'h86);
    io_write(8'h06, 8'h00);

    // 3: masked request stays pending until unmasked
    io_write(8'h04, 8'h01);
    irq_pulse(4'b0001);
    chk("t3_nint_masked", int'(nINT), 1);
    io_read(8'h05, v, oe); chk("t3_stat", int'(v), 8'h01);
    io_write(8'h04, 8'h00);
    chk("t3_nint_unmasked", int'(nINT), 0);
    inta('0, v); chk("t3_vec", int'(v), 8'h80);
    io_write(8'h06, 8'h00);

    // 4: mask before acknowledge, spurious vector
    irq_pulse(4'b0010);
    chk("t4_nint", int'(nINT), 0);
    io_write(8'h04, 8'h02);
    chk("t4_nint_masked", int'(nINT), 1);
    inta('0, v); chk("t4_spurious", int'(v), 8'h88);
    io_read(8'h05, v, oe); chk("t4_stat", int'(v), 8'h02);
    io_write(8'h04, 8'h00);
    inta('0, v); chk("t4_vec", int'(v), 8'h82);
    io_write(8'h06, 8'h00);

    // 5: higher-priority request while another is in service
    irq_pulse(4'b0100);
    inta('0, v); chk("t5_vec_a", int'(v), 8'h84);
    irq_pulse(4'b0001);
`ifdef Z80_INT_NESTED_EN
    chk("t5_nint_preempt", int'(nINT), 0);
    inta('0, v); chk("t5_vec_b", int'(v), 8'h80);
    io_read(8'h05, v, oe); chk("t5_stat", int'(v), 8'h50);
    io_write(8'h06, 8'h00);
    io_read(8'h05, v, oe); chk("t5_stat_eoi", int'(v), 8'h40);
    io_write(8'h06, 8'h00);
`else
    chk("t5_nint_wait", int'(nINT), 1);
    io_read(8'h05, v, oe); chk("t5_stat", int'(v), 8'h41);
    io_write(8'h06, 8'h00);
    chk("t5_nint_after_eoi", int'(nINT), 0);
    inta('0, v); chk("t5_vec_b", int'(v), 8'h80);
    io_write(8'h06, 8'h00);
`endif

    // set wins: new edge on the acknowledged source in the clear cycle
    irq_pulse(4'b0010);
    inta(4'b0010, v); chk("sw_vec", int'(v), 8'h82);
    io_read(8'h05, v, oe); chk("sw_stat", int'(v), 8'h22);
    io_write(8'h06, 8'h00);
    chk("sw_nint", int'(nINT), 0);
    inta('0, v); chk("sw_vec2", int'(v), 8'h82);
    io_write(8'h06, 8'h00);

    // unclaimed port and memory read never drive the bus
    io_read(8'h07, v, oe); chk("other_port_oe", int'(oe), 0);
    tick(1);
    Address = 8'h04; nRD = 1'b0;
    mark();
    tick(8); chk("memrd_oe", int'(DataOe), 0);
    nRD = 1'b1;
    mark();
    tick(6);

    // 6: reset during the vector phase, INTA pins still held afterwards
    irq_pulse(4'b0001);
    inta_begin('0);
    tick(3);
    chk("t6_vec", int'(DataOut), 8'h80);
    reset = 1'b1;
    mark();
    m_pend = '0; m_isv = '0; m_mask = '1; m_phase = 0;
    @(posedge clk); #1;
    chk("t6_rst_oe", int'(DataOe), 0);
    chk("t6_rst_nint", int'(nINT), 1);
    tick(3);
    reset = 1'b0;
    mark();
    tick(8);
    chk("t6_no_reanswer", int'(DataOe), 0);
    nM1 = 1'b1; nIORQ = 1'b1;
    mark();
    tick(6);
    io_read(8'h05, v, oe); chk("t6_stat", int'(v), 8'h00);
    io_read(8'h04, v, oe); chk("t6_mask", int'(v), 8'h0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
